// File: rtl/cpu_clock_ctl.sv
// CPU T-state clock-enable generator with +3 style memory contention stalls.
// Optional feature: define CPU_TURBO_EN to add a `turbo` input that halves the T-state period.
module cpu_clock_ctl #(
    parameter int DIV  = 8,
    parameter int CWIN = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mreq,
    input  logic [1:0] a,
    input  logic       ramc,
    input  logic       border,
    input  logic [2:0] hphase,
    output logic       pe,
    output logic       ne,
    output logic       hold
`ifdef CPU_TURBO_EN
    ,
    input  logic       turbo
`endif
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST_N = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_N = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] LAST_T = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] HALF_T = CW'(DIV / 4 - 1);
    localparam logic [3:0]    CWIN_V = 4'(CWIN);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            pe_q, pe_d;
    logic            ne_q, ne_d;
    logic            turbo_q;
    logic [CW-1:0]   lastCnt;
    logic [CW-1:0]   halfCnt;
    logic            wrap;
    logic            cadr;
    logic            stall;

    // Turbo mode is latched only at a period wrap so a period is never cut short.
`ifdef CPU_TURBO_EN
    logic turbo_d;
    assign turbo_d = wrap ? turbo : turbo_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            turbo_q <= 1'b0;
        end else begin
            turbo_q <= turbo_d;
        end
    end
`else
    assign turbo_q = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            pe_q    <= 1'b0;
            ne_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            pe_q    <= pe_d;
            ne_q    <= ne_d;
        end
    end

    // The RUN/STALL decision is taken only on the last clock of each period.
    always_comb begin
        lastCnt = turbo_q ? LAST_T : LAST_N;
        halfCnt = turbo_q ? HALF_T : HALF_N;
        wrap    = (cnt_q == lastCnt);
        cadr    = (a == 2'b01) | ((a == 2'b11) & ramc);
        stall   = ~mreq & cadr & ~border & ({1'b0, hphase} < CWIN_V) & ~done_q & ~turbo_q;

        cnt_d   = wrap ? '0 : cnt_q + 1'b1;
        state_d = state_q;
        pe_d    = 1'b0;
        ne_d    = (cnt_q == halfCnt) & (state_q == RUN);

        if (wrap) begin
            state_d = stall ? STALL : RUN;
            pe_d    = ~stall;
        end

        // One contention per access: once the CPU has advanced, the access is no longer stallable.
        if (mreq) begin
            done_d = 1'b0;
        end else if (pe_d) begin
            done_d = 1'b1;
        end else begin
            done_d = done_q;
        end
    end

    assign pe   = pe_q;
    assign ne   = ne_q;
    assign hold = (state_q == STALL);

endmodule

// File: tb/tb_cpu_clock_ctl.sv
// Self-checking bench for cpu_clock_ctl: per-period stimulus rows feed a per-clock scoreboard.
// Turbo checks are compiled in only when CPU_TURBO_EN is defined.
`timescale 1ns/1ps
module tb_cpu_clock_ctl;

    localparam int DIV = 8;

    logic       clock  = 1'b0;
    logic       reset  = 1'b0;
    logic       mreq   = 1'b1;
    logic [1:0] a      = 2'b00;
    logic       ramc   = 1'b0;
    logic       border = 1'b0;
    logic [2:0] hphase = 3'd0;
    logic       pe;
    logic       ne;
    logic       hold;
`ifdef CPU_TURBO_EN
    logic       turbo  = 1'b0;
`endif

    int total    = 0;
    int bad      = 0;
    int periodNo = 0;
    logic holdCur = 1'b0;

    typedef struct packed {
        logic pe;
        logic ne;
        logic hold;
    } exp_t;

    typedef struct {
        logic       mreq;
        logic [1:0] a;
        logic       ramc;
        logic       border;
        logic [2:0] hphase;
        logic       run;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    cpu_clock_ctl #(.DIV(DIV), .CWIN(6)) dut (
        .clock  (clock),
        .reset  (reset),
        .mreq   (mreq),
        .a      (a),
        .ramc   (ramc),
        .border (border),
        .hphase (hphase),
        .pe     (pe),
        .ne     (ne),
        .hold   (hold)
`ifdef CPU_TURBO_EN
        ,
        .turbo  (turbo)
`endif
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input logic m, input logic [1:0] ad, input logic r,
                                input logic b, input logic [2:0] h, input logic run);
        vec_t v;
        v.mreq = m; v.a = ad; v.ramc = r; v.border = b; v.hphase = h; v.run = run;
        return v;
    endfunction

    task automatic checkOutput(input string name, input exp_t want);
        exp_t got;
        got = {pe, ne, hold};
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s period=%0d pe/ne/hold got %b%b%b want %b%b%b",
                     name, periodNo, got.pe, got.ne, got.hold, want.pe, want.ne, want.hold);
        end
    endtask

    // Scoreboard consumer: one expected triple per clock, sampled just after the edge.
    always @(posedge clock) begin
        #1;
        if (sb.size() > 0) checkOutput("cycle", sb.pop_front());
    end

    // Drives one T-state worth of inputs and queues what each of its clocks must show.
    task automatic applyStimulus(input vec_t v, input int nClk, input int perLen);
        mreq   = v.mreq;
        a      = v.a;
        ramc   = v.ramc;
        border = v.border;
        hphase = v.hphase;
        for (int k = 1; k <= nClk; k++) begin
            exp_t e;
            e.pe   = (k == perLen) & v.run;
            e.ne   = (k == perLen / 2) & ~holdCur;
            e.hold = (k == perLen) ? ~v.run : holdCur;
            sb.push_back(e);
        end
        repeat (nClk) @(posedge clock);
        #2;
        if (nClk == perLen) holdCur = ~v.run;
        periodNo++;
    endtask

    initial begin
        vecs.push_back(mk(1, 2'b00, 0, 0, 3'd6, 1));
        vecs.push_back(mk(1, 2'b00, 0, 0, 3'd7, 1));
        vecs.push_back(mk(1, 2'b00, 0, 0, 3'd0, 1));
        vecs.push_back(mk(1, 2'b00, 0, 0, 3'd1, 1));
        vecs.push_back(mk(0, 2'b01, 0, 0, 3'd2, 0));
        vecs.push_back(mk(0, 2'b01, 0, 0, 3'd3, 0));
        vecs.push_back(mk(0, 2'b01, 0, 0, 3'd4, 0));
        vecs.push_back(mk(0, 2'b01, 0, 0, 3'd5, 0));
        vecs.push_back(mk(0, 2'b01, 0, 0, 3'd6, 1));
        vecs.push_back(mk(0, 2'b01, 0, 0, 3'd7, 1));
        vecs.push_back(mk(0, 2'b01, 0, 0, 3'd0, 1));
        vecs.push_back(mk(1, 2'b01, 0, 0, 3'd1, 1));
        vecs.push_back(mk(0, 2'b01, 0, 0, 3'd2, 0));
        vecs.push_back(mk(1, 2'b01, 0, 0, 3'd3, 1));
        vecs.push_back(mk(0, 2'b01, 0, 1, 3'd0, 1));
        vecs.push_back(mk(1, 2'b00, 0, 0, 3'd1, 1));
        vecs.push_back(mk(0, 2'b10, 0, 0, 3'd2, 1));
        vecs.push_back(mk(1, 2'b00, 0, 0, 3'd3, 1));
        vecs.push_back(mk(0, 2'b11, 0, 0, 3'd0, 1));
        vecs.push_back(mk(1, 2'b00, 0, 0, 3'd1, 1));
        for (int h = 0; h < 6; h++) vecs.push_back(mk(0, 2'b11, 1, 0, 3'(h), 0));
        vecs.push_back(mk(0, 2'b11, 1, 0, 3'd6, 1));
        vecs.push_back(mk(1, 2'b00, 0, 0, 3'd7, 1));
        vecs.push_back(mk(0, 2'b01, 0, 0, 3'd3, 0));
        vecs.push_back(mk(0, 2'b01, 0, 1, 3'd4, 1));
        vecs.push_back(mk(1, 2'b00, 0, 0, 3'd5, 1));
        vecs.push_back(mk(0, 2'b00, 0, 0, 3'd0, 1));
        vecs.push_back(mk(1, 2'b01, 0, 0, 3'd0, 1));
        vecs.push_back(mk(0, 2'b11, 1, 0, 3'd7, 1));
        vecs.push_back(mk(1, 2'b00, 0, 0, 3'd0, 1));

        repeat (3) @(posedge clock);
        #2;
        checkOutput("reset state", 3'b000);

        @(negedge clock);
        reset   = 1'b1;
        holdCur = 1'b0;
        foreach (vecs[i]) applyStimulus(vecs[i], DIV, DIV);

        // Reset asserted in the middle of the second stalled T-state.
        applyStimulus(mk(1, 2'b00, 0, 0, 3'd1, 1), DIV, DIV);
        applyStimulus(mk(0, 2'b01, 0, 0, 3'd2, 0), DIV, DIV);
        applyStimulus(mk(0, 2'b01, 0, 0, 3'd3, 0), DIV, DIV);
        applyStimulus(mk(0, 2'b01, 0, 0, 3'd4, 0), 3, DIV);
        checkOutput("hold before reset", 3'b001);
        #1 reset = 1'b0;
        #1 checkOutput("async reset mid stall", 3'b000);
        repeat (2) @(posedge clock);
        #2 checkOutput("held in reset", 3'b000);
        @(negedge clock);
        reset   = 1'b1;
        holdCur = 1'b0;
        mreq    = 1'b1;
        applyStimulus(mk(1, 2'b00, 0, 0, 3'd0, 1), DIV, DIV);
        applyStimulus(mk(1, 2'b00, 0, 0, 3'd1, 1), DIV, DIV);

`ifdef CPU_TURBO_EN
        // Turbo raised right after a wrap: this period keeps full length.
        turbo = 1'b1;
        applyStimulus(mk(1, 2'b00, 0, 0, 3'd2, 1), DIV, DIV);
        applyStimulus(mk(0, 2'b01, 0, 0, 3'd0, 1), DIV / 2, DIV / 2);
        applyStimulus(mk(1, 2'b00, 0, 0, 3'd1, 1), DIV / 2, DIV / 2);
        applyStimulus(mk(0, 2'b11, 1, 0, 3'd2, 1), DIV / 2, DIV / 2);
        turbo = 1'b0;
        applyStimulus(mk(1, 2'b00, 0, 0, 3'd3, 1), DIV / 2, DIV / 2);
        applyStimulus(mk(1, 2'b00, 0, 0, 3'd4, 1), DIV, DIV);
        applyStimulus(mk(1, 2'b00, 0, 0, 3'd5, 1), DIV, DIV);
`endif

        repeat (2) @(posedge clock);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard drain left=%0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
